delay_counter: RTL and testbench

//   Programmable microsecond delay timer. A level-sensitive start input arms it.

---
 rtl/delay_counter_pkg.sv | 12 +
 rtl/delay_counter_us_tick_gen.sv | 32 +++
 rtl/delay_counter.sv | 70 +++++++
 tb/tb_delay_counter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/delay_counter_pkg.sv
// Shared constants and the counter-width helper for the microsecond delay timer.
package delay_counter_pkg;

  // Shortest possible delay; a zero-length request still takes one edge.
  localparam int MIN_DELAY_CYCLES = 1;

  // Bits needed to hold every value in 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/delay_counter_us_tick_gen.sv
// One-microsecond prescaler: counts clock cycles while enabled and pulses
// tick on the last cycle of every microsecond. Held at zero while disabled.
module us_tick_gen #(
  parameter int CLOCK_SPEED_MHZ = 12
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic tick
);
  import delay_counter_pkg::*;

  localparam int             PW    = cnt_width(CLOCK_SPEED_MHZ);
  localparam logic [PW-1:0]  P_TOP = PW'(CLOCK_SPEED_MHZ - 1);

  logic [PW-1:0] presc_reg = '0;

  // tick is qualified by en so a disabled prescaler never reports a microsecond.
  assign tick = en && (presc_reg == P_TOP);

  // Prescaler: clear when idle, wrap at the top of each microsecond.
  always_ff @(posedge CLK) begin
    if (RST || !en) begin
      presc_reg <= '0;
    end else if (presc_reg == P_TOP) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

endmodule

// File: rtl/delay_counter.sv
// Programmable microsecond delay: out rises after CLOCK_SPEED_MHZ*US_DELAY
// consecutive edges with start high, and stays high until start drops.
module delay_counter #(
  parameter int CLOCK_SPEED_MHZ = 12,
  parameter int US_DELAY        = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic start,
  output logic out
);
  import delay_counter_pkg::*;

  logic out_reg = 1'b0;

  assign out = out_reg;

  generate
    if (CLOCK_SPEED_MHZ * US_DELAY < MIN_DELAY_CYCLES) begin : g_bypass
      // Zero-length delay: out simply follows start, one edge late.
      always_ff @(posedge CLK) begin
        if (RST) begin
          out_reg <= 1'b0;
        end else begin
          out_reg <= start;
        end
      end
    end else begin : g_count
      localparam int            UW     = cnt_width(US_DELAY + 1);
      localparam logic [UW-1:0] U_LAST = UW'(US_DELAY - 1);
      localparam logic [UW-1:0] U_TOP  = UW'(US_DELAY);

      logic          tick;
      logic          terminal;
      logic [UW-1:0] us_cnt_reg = '0;

      // Prescaler stops once done so both counters sit at their final values.
      us_tick_gen #(
        .CLOCK_SPEED_MHZ (CLOCK_SPEED_MHZ)
      ) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .en   (start && !out_reg),
        .tick (tick)
      );

      // The final microsecond completes on this cycle's edge.
      assign terminal = tick && (us_cnt_reg == U_LAST);

      // Microsecond counter: cleared when idle, saturates at US_DELAY.
      always_ff @(posedge CLK) begin
        if (RST || !start) begin
          us_cnt_reg <= '0;
        end else if (tick && (us_cnt_reg != U_TOP)) begin
          us_cnt_reg <= us_cnt_reg + UW'(1);
        end
      end

      // Done flag: set at the terminal edge, held while start stays high.
      always_ff @(posedge CLK) begin
        if (RST || !start) begin
          out_reg <= 1'b0;
        end else if (terminal) begin
          out_reg <= 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_delay_counter.sv
// Self-checking bench: four parameterisations driven by a shared start/RST,
// each compared every cycle against a run-length reference model.
module tb_delay_counter;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic start = 1'b0;
  logic out0, out1, out2, out3;

  int total = 0;
  int bad   = 0;

  // Reference model: consecutive start=1 edges since the last clear,
  // and the delay length in cycles for each instance.
  int run  [4];
  int ncyc [4];

  always #5 CLK = ~CLK;

  delay_counter #(.CLOCK_SPEED_MHZ(12), .US_DELAY(2)) u0 (
    .CLK(CLK), .RST(RST), .start(start), .out(out0));
  delay_counter #(.CLOCK_SPEED_MHZ(1), .US_DELAY(1)) u1 (
    .CLK(CLK), .RST(RST), .start(start), .out(out1));
  delay_counter #(.CLOCK_SPEED_MHZ(12), .US_DELAY(0)) u2 (
    .CLK(CLK), .RST(RST), .start(start), .out(out2));
  delay_counter #(.CLOCK_SPEED_MHZ(48), .US_DELAY(120)) u3 (
    .CLK(CLK), .RST(RST), .start(start), .out(out3));

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic dut_out(input int i);
    case (i)
      0:       return out0;
      1:       return out1;
      2:       return out2;
      default: return out3;
    endcase
  endfunction

  // Apply one edge worth of inputs, advance the model, compare all instances.
  task automatic step(input logic r, input logic s);
    RST   = r;
    start = s;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (r || !s) run[i] = 0;
      else if (run[i] < 100000) run[i]++;
      check($sformatf("model_u%0d", i), dut_out(i), (run[i] >= ncyc[i]) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    ncyc[0] = 24;
    ncyc[1] = 1;
    ncyc[2] = 1;
    ncyc[3] = 5760;
    for (int i = 0; i < 4; i++) run[i] = 0;

    // Reset
    @(negedge CLK);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("reset_u0", out0, 1'b0);
    check("reset_u2", out2, 1'b0);
    $display("reset applied: out=%0b%0b%0b%0b", out3, out2, out1, out0);

    // Test 1: latency of the default instance
    for (int e = 1; e <= 24; e++) begin
      step(1'b0, 1'b1);
      if (e == 1) begin
        check("t1_u1_edge1", out1, 1'b1);
        check("t1_u2_edge1", out2, 1'b1);
      end
      if (e == 23) check("t1_u0_edge23", out0, 1'b0);
    end
    check("t1_u0_edge24", out0, 1'b1);
    $display("t1 latency: 24 edges, out0=%0b", out0);

    // Test 2: hold
    for (int e = 0; e < 100; e++) step(1'b0, 1'b1);
    check("t2_hold", out0, 1'b1);
    $display("t2 hold: 100 edges, out0=%0b", out0);

    // Test 3: abort mid-count
    step(1'b0, 1'b0);
    for (int e = 0; e < 10; e++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("t3_abort", out0, 1'b0);
    for (int e = 1; e <= 24; e++) begin
      step(1'b0, 1'b1);
      if (e == 23) check("t3_edge23", out0, 1'b0);
    end
    check("t3_edge24", out0, 1'b1);
    $display("t3 abort/restart: out0=%0b", out0);

    // Test 4: reset mid-count
    step(1'b0, 1'b0);
    for (int e = 0; e < 15; e++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("t4_rst", out0, 1'b0);
    for (int e = 1; e <= 24; e++) begin
      step(1'b0, 1'b1);
      if (e == 23) check("t4_edge23", out0, 1'b0);
    end
    check("t4_edge24", out0, 1'b1);
    $display("t4 reset mid-count: out0=%0b", out0);

    // Test 5: release and re-arm
    step(1'b0, 1'b0);
    check("t5_release", out0, 1'b0);
    for (int e = 1; e <= 24; e++) begin
      step(1'b0, 1'b1);
      if (e == 23) check("t5_edge23", out0, 1'b0);
    end
    check("t5_edge24", out0, 1'b1);
    $display("t5 release/re-arm: out0=%0b", out0);

    // Test 6: long delay instance, 5760 cycles
    step(1'b0, 1'b0);
    for (int e = 1; e <= 5800; e++) begin
      step(1'b0, 1'b1);
      if (e == 5759) check("t6_u3_edge5759", out3, 1'b0);
      if (e == 5760) check("t6_u3_edge5760", out3, 1'b1);
    end
    check("t6_u3_hold", out3, 1'b1);
    $display("t6 long delay: out3=%0b", out3);

    // Randomized: mostly-high start with occasional drops and resets
    for (int e = 0; e < 3000; e++) begin
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 29) != 0) ? 1'b1 : 1'b0);
    end
    $display("random phase: 3000 edges");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
